// File: rtl/centscale_fifo.sv
// centscale_fifo
// Elastic first-word-fall-through buffer behind the center/scale stage.
// Samples strobed in while the buffer is full (and not popping in the same
// cycle) are dropped and reported through a sticky flag and a saturating
// drop counter.
//
// Ports:
//   clk          rising-edge clock
//   GlobalReset  asynchronous active-low reset
//   x_centScale  32-bit SMC-float sample in
//   srdyi        sample strobe (one sample per high cycle)
//   x_o          head-of-FIFO sample, valid while srdyo_o=1
//   srdyo_o      FIFO non-empty
//   drdyi        consumer ready; pop on srdyo_o & drdyi
//   count_o      occupancy 0..DEPTH
//   full_o       occupancy == DEPTH
//   ovf_o        sticky overflow flag
//   drop_cnt_o   dropped-sample count, saturates at 255
//   ovf_clr      synchronous clear of ovf_o / drop_cnt_o
module centscale_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          GlobalReset,
    input  logic [31:0]   x_centScale,
    input  logic          srdyi,
    output logic [31:0]   x_o,
    output logic          srdyo_o,
    input  logic          drdyi,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          ovf_o,
    output logic [7:0]    drop_cnt_o,
    input  logic          ovf_clr
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic pop;
    logic push;
    logic drop;

    assign srdyo_o    = (cnt_q != '0);
    assign full_o     = (cnt_q == FULL_CNT);
    assign count_o    = cnt_q;
    assign x_o        = mem_q[rd_ptr_q];
    assign ovf_o      = ovf_q;
    assign drop_cnt_o = drop_cnt_q;

    // A full FIFO still accepts a sample when a pop frees a slot this cycle.
    assign pop  = srdyo_o & drdyi;
    assign push = srdyi & (~full_o | pop);
    assign drop = srdyi & ~push;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase

        // A drop coinciding with a clear wins: the clear is applied first,
        // then the new drop is counted on top of it.
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr)
                drop_cnt_d = 8'd1;
            else if (drop_cnt_q != '1)
                drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= x_centScale;
    end

endmodule

// File: tb/tb_centscale_fifo.sv
// tb_centscale_fifo
// Directed bench for centscale_fifo (DEPTH=8). A reference queue holds the
// samples the consumer is owed; occupancy, valid and head data are compared
// against it every cycle, and the overflow/drop behaviour is checked with
// hand-computed constants.
module tb_centscale_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk;
    logic          GlobalReset;
    logic [31:0]   x_centScale;
    logic          srdyi;
    logic [31:0]   x_o;
    logic          srdyo_o;
    logic          drdyi;
    logic [AW:0]   count_o;
    logic          full_o;
    logic          ovf_o;
    logic [7:0]    drop_cnt_o;
    logic          ovf_clr;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [31:0] exp_q [$];

    centscale_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .x_centScale (x_centScale),
        .srdyi       (srdyi),
        .x_o         (x_o),
        .srdyo_o     (srdyo_o),
        .drdyi       (drdyi),
        .count_o     (count_o),
        .full_o      (full_o),
        .ovf_o       (ovf_o),
        .drop_cnt_o  (drop_cnt_o),
        .ovf_clr     (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle of stimulus. Entered and left at posedge+1.
    task automatic cyc(input logic s, input logic [31:0] d, input logic r, input logic clr);
        int sz;
        bit popped;
        srdyi = s; x_centScale = d; drdyi = r; ovf_clr = clr;
        #1;
        sz = exp_q.size();
        chk("srdyo", 32'(srdyo_o), 32'(sz != 0));
        chk("count", 32'(count_o), 32'(sz));
        popped = (sz != 0) && r;
        if (popped) begin
            chk("x_o", x_o, exp_q[0]);
            void'(exp_q.pop_front());
        end
        if (s && (sz < int'(DEPTH) || popped)) exp_q.push_back(d);
        @(posedge clk);
        #1;
        srdyi = 1'b0; drdyi = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        GlobalReset = 1'b0; srdyi = 1'b0; drdyi = 1'b0; ovf_clr = 1'b0;
        x_centScale = '0;
        repeat (2) @(posedge clk);
        #1 GlobalReset = 1'b1;

        // Reset and basic passthrough: reset hits mid-stream
        cyc(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
        cyc(1'b1, 32'hAAAA0002, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count_o), 32'd2);
        GlobalReset = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_srdyo", 32'(srdyo_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_full",  32'(full_o),  32'd0);
        chk("rst_ovf",   32'(ovf_o),   32'd0);
        chk("rst_drop",  32'(drop_cnt_o), 32'd0);
        @(posedge clk);
        #1 GlobalReset = 1'b1;
        cyc(1'b1, 32'h3F800000, 1'b0, 1'b0);
        cyc(1'b1, 32'h40000000, 1'b0, 1'b0);
        cyc(1'b1, 32'hC0400000, 1'b0, 1'b0);
        chk("t1_count", 32'(count_o), 32'd3);
        chk("t1_head",  x_o, 32'h3F800000);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t1_empty", 32'(srdyo_o), 32'd0);

        // Fill to full and overflow
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 8) begin
                chk("t2_full8", 32'(full_o), 32'd1);
                chk("t2_ovf8",  32'(ovf_o),  32'd0);
            end
        end
        chk("t2_ovf",  32'(ovf_o), 32'd1);
        chk("t2_drop", 32'(drop_cnt_o), 32'd2);
        chk("t2_count", 32'(count_o), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            chk("t2_drain", x_o, 32'(i));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        chk("t2_empty", 32'(srdyo_o), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("t2_clr_ovf",  32'(ovf_o), 32'd0);
        chk("t2_clr_drop", 32'(drop_cnt_o), 32'd0);

        // Simultaneous push and pop while full
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
            chk("t3_count", 32'(count_o), 32'd8);
            chk("t3_ovf",   32'(ovf_o),   32'd0);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t3_empty", 32'(srdyo_o), 32'd0);

        // Wrap-around under streaming: 100 samples, ready toggling period 3
        begin
            int sent;
            int c;
            sent = 0; c = 0;
            while (sent < 100) begin
                if ((c % 3) != 0) begin
                    cyc(1'b1, 32'h5000 + 32'(sent), (c % 3) != 1, 1'b0);
                    sent++;
                end else begin
                    cyc(1'b0, '0, 1'b1, 1'b0);
                end
                c++;
            end
        end
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t4_empty", 32'(srdyo_o), 32'd0);
        chk("t4_ovf",   32'(ovf_o),   32'd0);
        chk("t4_drop",  32'(drop_cnt_o), 32'd0);

        // Drop-counter saturation and clear collision
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h7000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 32'hDEAD0000 + 32'(i), 1'b0, 1'b0);
        chk("t5_sat",     32'(drop_cnt_o), 32'd255);
        chk("t5_ovf",     32'(ovf_o),      32'd1);
        cyc(1'b1, 32'hBAD0BAD0, 1'b0, 1'b1);
        chk("t5_col_ovf",  32'(ovf_o),      32'd1);
        chk("t5_col_drop", 32'(drop_cnt_o), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("t5_clr_ovf",  32'(ovf_o),      32'd0);
        chk("t5_clr_drop", 32'(drop_cnt_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t5_drain", x_o, 32'h7000 + 32'(i));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end

        // Empty-boundary pop with ready held high
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t6_cnt0", 32'(count_o), 32'd0);
        cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("t6_srdyo1", 32'(srdyo_o), 32'd1);
        chk("t6_cnt1",   32'(count_o), 32'd1);
        chk("t6_x",      x_o, 32'hDEADBEEF);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t6_srdyo0", 32'(srdyo_o), 32'd0);
        chk("t6_cnt0b",  32'(count_o), 32'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
